// File: rtl/alarm_sched_pkg.sv
// Shared definitions for the alarm scheduler slice.
//   ID_W    : width of a channel index (covers up to 8 channels)
//   MAX_N   : largest supported channel count
//   state_t : scheduler FSM states
//   onehot  : channel index -> one-hot vector of MAX_N bits
package alarm_sched_pkg;

    localparam int ID_W  = 3;
    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUZZ,
        GAP
    } state_t;

    // Callers slice the low N bits for their own channel count.
    function automatic logic [MAX_N-1:0] onehot(input logic [ID_W-1:0] id);
        logic [MAX_N-1:0] one;
        one = {{(MAX_N-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Ports:
//   req       : request vector, one bit per channel
//   ptr       : index of the most recently granted channel; the search
//               starts at ptr+1 and wraps modulo N
//   gnt_valid : at least one request is present
//   gnt_id    : index of the winning channel (0 when gnt_valid=0)
module rr_arbiter
    import alarm_sched_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    logic [MAX_N-1:0] req_ext;
    logic [ID_W-1:0]  idx;

    // Walk the candidates from lowest to highest priority so that the last
    // hit, which is the closest channel after ptr, is the one that sticks.
    // The request vector is widened to MAX_N so a full-width index works
    // for any N.
    always_comb begin
        req_ext   = MAX_N'(req);
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = N; k >= 1; k--) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (req_ext[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Shares a single buzzer drive across N sensor channels. Requests are
// latched as sticky pending bits and served round-robin. Each grant is an
// ON_CYCLES burst on one buzzer, followed by GAP_CYCLES of silence.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   ena        : scheduler enable; when low the FSM idles but still captures
//   sensor_in  : level request per channel
//   buzzer_out : registered one-hot (or zero) buzzer drive
//   active_id  : index of the granted channel, meaningful while busy=1
//   busy       : high while a burst is in progress
//   pending    : sticky request register
module alarm_scheduler
    import alarm_sched_pkg::*;
#(
    parameter int N          = 8,
    parameter int ON_CYCLES  = 10,
    parameter int GAP_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N-1:0]    sensor_in,
    output logic [N-1:0]    buzzer_out,
    output logic [ID_W-1:0] active_id,
    output logic            busy,
    output logic [N-1:0]    pending
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  rr_ptr;

    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic [MAX_N-1:0] gnt_hot_full;
    logic [N-1:0]     gnt_hot;
    logic             arb_slot;
    logic             grant_now;
    logic [N-1:0]     pending_next;

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // An arbitration slot opens when idle, at the end of a gap, or straight
    // at the end of a burst when the build has no gap. A grant happens only
    // in such a slot with the scheduler enabled and something pending.
    // The granted channel's pending bit is reloaded from its sensor, so a
    // sensor that is still high re-queues itself immediately.
    always_comb begin
        gnt_hot_full = onehot(gnt_id);
        gnt_hot      = gnt_hot_full[N-1:0];
        arb_slot     = (state == IDLE)
                     || ((state == BUZZ) && (cnt == '0) && (GAP_CYCLES == 0))
                     || ((state == GAP)  && (cnt == '0));
        grant_now    = ena && arb_slot && gnt_valid;
        if (grant_now) begin
            pending_next = ((pending | sensor_in) & ~gnt_hot) | (sensor_in & gnt_hot);
        end else begin
            pending_next = pending | sensor_in;
        end
    end

    // Scheduler FSM with registered outputs. Reset beats everything, a low
    // enable forces the FSM silent next, and otherwise a grant takes
    // precedence over normal burst/gap counting. Pending capture runs
    // whenever reset is low, independent of the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= PTR_INIT;
            pending    <= '0;
            buzzer_out <= '0;
            active_id  <= '0;
            busy       <= 1'b0;
        end else begin
            pending <= pending_next;
            if (!ena) begin
                state      <= IDLE;
                buzzer_out <= '0;
                busy       <= 1'b0;
                cnt        <= '0;
            end else if (grant_now) begin
                state      <= BUZZ;
                buzzer_out <= gnt_hot;
                active_id  <= gnt_id;
                busy       <= 1'b1;
                cnt        <= ON_LOAD;
                rr_ptr     <= gnt_id;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    BUZZ: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state      <= GAP;
                            buzzer_out <= '0;
                            busy       <= 1'b0;
                            cnt        <= GAP_LOAD;
                        end else begin
                            state      <= IDLE;
                            buzzer_out <= '0;
                            busy       <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler. Two instances share stimulus:
// dut uses the default build (gap of 2 cycles), dut_g0 is built with
// GAP_CYCLES=0. Expected grant sequences are queued as stimulus is
// applied. A monitor turns the buzzer waveform of dut into burst records
// (channel, length, preceding silence), which the scenario tasks pop and
// compare against the queued expectations.
module tb_alarm_scheduler;

    typedef struct {
        logic [7:0] hot;
        logic [2:0] aid;
        int         len;
        int         gap;
    } burst_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] sensor_in;

    logic [7:0] buzzer_out;
    logic [2:0] active_id;
    logic       busy;
    logic [7:0] pending;

    logic [7:0] buzzer_g0;
    logic [2:0] active_id_g0;
    logic       busy_g0;
    logic [7:0] pending_g0;

    int     checks = 0;
    int     errors = 0;
    int     exp_q[$];
    burst_t obs_q[$];

    logic [7:0] mon_prev;
    logic [2:0] mon_aid;
    int         mon_run;
    int         mon_zrun;
    int         mon_gap;

    alarm_scheduler #(
        .N          (8),
        .ON_CYCLES  (10),
        .GAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sensor_in  (sensor_in),
        .buzzer_out (buzzer_out),
        .active_id  (active_id),
        .busy       (busy),
        .pending    (pending)
    );

    alarm_scheduler #(
        .N          (8),
        .ON_CYCLES  (10),
        .GAP_CYCLES (0)
    ) dut_g0 (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sensor_in  (sensor_in),
        .buzzer_out (buzzer_g0),
        .active_id  (active_id_g0),
        .busy       (busy_g0),
        .pending    (pending_g0)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor sampling on the falling edge: checks that both instances are
    // never multi-hot and that busy tracks the buzzer, and records every
    // completed burst of dut into obs_q.
    initial begin
        mon_prev = '0;
        mon_aid  = '0;
        mon_run  = 0;
        mon_zrun = 0;
        mon_gap  = 0;
        forever begin
            @(negedge clk);
            checks++;
            if (!$onehot0(buzzer_out) || !$onehot0(buzzer_g0)) begin
                errors++;
                $display("[TB] FAIL onehot0: buzzer_out=%h buzzer_g0=%h", buzzer_out, buzzer_g0);
            end
            checks++;
            if (busy !== (buzzer_out != 8'h00) || busy_g0 !== (buzzer_g0 != 8'h00)) begin
                errors++;
                $display("[TB] FAIL busy_track: busy=%b buzzer=%h busy_g0=%b buzzer_g0=%h",
                         busy, buzzer_out, busy_g0, buzzer_g0);
            end
            if (rst) begin
                mon_prev = '0;
                mon_run  = 0;
                mon_zrun = 0;
            end else if (buzzer_out == mon_prev) begin
                if (mon_prev == 8'h00) mon_zrun++;
                else                   mon_run++;
            end else begin
                if (mon_prev != 8'h00) begin
                    obs_q.push_back('{hot: mon_prev, aid: mon_aid, len: mon_run, gap: mon_gap});
                end
                if (buzzer_out != 8'h00) begin
                    mon_gap  = (mon_prev == 8'h00) ? mon_zrun : 0;
                    mon_aid  = active_id;
                    mon_run  = 1;
                end else begin
                    mon_zrun = 1;
                end
                mon_prev = buzzer_out;
            end
        end
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rst       = 1'b1;
        ena       = 1'b1;
        sensor_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_bursts(input int k, input int limit, output bit ok);
        for (int c = 0; c < limit && obs_q.size() < k; c++) @(negedge clk);
        ok = (obs_q.size() >= k);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ena       = 1'b1;
        sensor_in = 8'hFF;
        repeat (2) @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_buzzer: got %h expected 00", buzzer_out);
        end
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_pending: got %h expected 00", pending);
        end
        checks++;
        if (busy !== 1'b0 || active_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_busy_id: busy=%b id=%0d expected 0/0", busy, active_id);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pending !== 8'hFF || buzzer_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_release: pending=%h buzzer=%h expected FF/00", pending, buzzer_out);
        end
        @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h01 || active_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: buzzer=%h id=%0d expected 01/0", buzzer_out, active_id);
        end
        sensor_in = 8'h00;
    endtask

    task automatic test_single();
        burst_t r;
        bit     ok;
        bit     quiet;
        do_reset();
        sensor_in = 8'h01;
        exp_q.push_back(0);
        @(negedge clk);
        sensor_in = 8'h00;
        checks++;
        if (pending !== 8'h01 || buzzer_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_capture: pending=%h buzzer=%h expected 01/00", pending, buzzer_out);
        end
        @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h01 || pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_grant: buzzer=%h pending=%h expected 01/00", buzzer_out, pending);
        end
        wait_bursts(1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_timeout: got %0d bursts expected 1", obs_q.size());
        end else begin
            r = obs_q.pop_front();
            checks++;
            if (r.hot !== (8'h01 << exp_q[0]) || r.len != 10) begin
                errors++;
                $display("[TB] FAIL single_burst: hot=%h len=%0d expected 01/10", r.hot, r.len);
            end
            void'(exp_q.pop_front());
        end
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (buzzer_out !== 8'h00) quiet = 1'b0;
        end
        checks++;
        if (!quiet || obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_idle: quiet=%b extra_bursts=%0d expected 1/0", quiet, obs_q.size());
        end
    endtask

    task automatic run_rotation(input string name, input logic [7:0] pattern, input int limit);
        burst_t     r;
        bit         ok;
        int         id;
        int         n;
        logic [7:0] eh;
        wait_bursts(exp_q.size(), limit, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d bursts expected %0d", name, obs_q.size(), exp_q.size());
        end
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            id = exp_q.pop_front();
            r  = obs_q.pop_front();
            eh = 8'h01 << id;
            checks++;
            if (r.hot !== eh || r.aid !== 3'(id) || r.len != 10 || (n > 0 && r.gap != 2)) begin
                errors++;
                $display("[TB] FAIL %s_burst%0d: hot=%h id=%0d len=%0d gap=%0d expected %h/%0d/10/2 (pattern %h)",
                         name, n, r.hot, r.aid, r.len, r.gap, eh, id, pattern);
            end
            n++;
        end
        sensor_in = 8'h00;
    endtask

    task automatic test_fairness();
        do_reset();
        sensor_in = 8'h06;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(2);
        run_rotation("fair", 8'h06, 200);
    endtask

    task automatic test_all_sensors();
        do_reset();
        sensor_in = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        run_rotation("all", 8'hFF, 400);
    endtask

    task automatic test_ena_drop();
        bit found;
        do_reset();
        sensor_in = 8'h09;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (buzzer_out === 8'h01) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL ena_first_grant: buzzer=%h expected 01", buzzer_out);
        end
        repeat (4) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ena_drop: buzzer=%h busy=%b expected 00/0", buzzer_out, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h00 || pending !== 8'h09 || active_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL ena_hold: buzzer=%h pending=%h id=%0d expected 00/09/0",
                     buzzer_out, pending, active_id);
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h08 || active_id !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ena_resume: buzzer=%h id=%0d busy=%b expected 08/3/1",
                     buzzer_out, active_id, busy);
        end
        sensor_in = 8'h00;
    endtask

    task automatic test_rst_mid();
        bit found;
        do_reset();
        sensor_in = 8'h06;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (buzzer_out === 8'h02) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL rstmid_first_grant: buzzer=%h expected 02", buzzer_out);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h00 || pending !== 8'h00 || busy !== 1'b0 || active_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_values: buzzer=%h pending=%h busy=%b id=%0d expected 00/00/0/0",
                     buzzer_out, pending, busy, active_id);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pending !== 8'h06 || buzzer_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rstmid_capture: pending=%h buzzer=%h expected 06/00", pending, buzzer_out);
        end
        @(negedge clk);
        checks++;
        if (buzzer_out !== 8'h02 || active_id !== 3'd1) begin
            errors++;
            $display("[TB] FAIL rstmid_regrant: buzzer=%h id=%0d expected 02/1", buzzer_out, active_id);
        end
        sensor_in = 8'h00;
    endtask

    task automatic test_back_to_back();
        bit         found;
        int         id;
        int         run;
        logic [7:0] eh;
        do_reset();
        sensor_in = 8'h28;
        exp_q.push_back(3);
        exp_q.push_back(5);
        @(negedge clk);
        sensor_in = 8'h00;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (buzzer_g0 !== 8'h00) found = 1'b1;
        end
        checks++;
        if (!found || pending_g0 !== 8'h20) begin
            errors++;
            $display("[TB] FAIL b2b_start: found=%b pending=%h expected 1/20", found, pending_g0);
        end
        while (exp_q.size() > 0) begin
            id  = exp_q.pop_front();
            eh  = 8'h01 << id;
            run = 0;
            while (buzzer_g0 === eh && run < 30) begin
                run++;
                @(negedge clk);
            end
            checks++;
            if (run != 10) begin
                errors++;
                $display("[TB] FAIL b2b_burst_ch%0d: got %0d cycles of %h expected 10 (now %h)",
                         id, run, eh, buzzer_g0);
            end
        end
        checks++;
        if (buzzer_g0 !== 8'h00 || pending_g0 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL b2b_end: buzzer=%h pending=%h expected 00/00", buzzer_g0, pending_g0);
        end
    endtask

    // Scenario sequence.
    initial begin
        rst       = 1'b1;
        ena       = 1'b1;
        sensor_in = 8'h00;
        $display("[TB] starting alarm_scheduler bench");
        test_reset();
        test_single();
        test_fairness();
        test_all_sensors();
        test_ena_drop();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Time-multiplexes a single buzzer driver budget across N sensor channels; at most one buzzer output is active at any time. Sensor requests are latched as sticky pending bits and served round-robin. Each grant is a fixed-length buzz burst followed by a silent gap. Sits between the sensor inputs (ui_in) and the buzzer outputs (uo_out) of the top-level alarm design, replacing direct sensor-to-buzzer mapping.

Parameters:
N, 8, number of sensor/buzzer channels (2..8)
ON_CYCLES, 10, buzz burst length in clk cycles (>=1)
GAP_CYCLES, 2, silent cycles after each burst (>=0)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  scheduler enable
sensor_in  input  N  level request per channel
buzzer_out  output  N  one-hot or zero buzzer drive, registered
active_id  output  3  index of granted channel, valid when busy=1
busy  output  1  high during a burst (state BUZZ)
pending  output  N  sticky request register, visible to host

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at edge): state IDLE, pending=0, buzzer_out=0, active_id=0, busy=0, cnt=0, rr_ptr=N-1 (first search starts at channel 0). rst wins over every other input, including mid-burst: buzzer drops on the next edge.
- Pending capture: every edge, pending[i] <= pending[i] | sensor_in[i], except for the channel granted on that edge, which becomes sensor_in[i] (set wins over clear when the sensor is still high).
- Arbitration: rotating priority over pending, search order rr_ptr+1, rr_ptr+2, … wrapping mod N; the winner w updates rr_ptr <= w.
- States:
  - IDLE: if ena and pending!=0 → BUZZ with winner w; buzzer_out <= 1<<w, active_id <= w, busy <= 1, cnt <= ON_CYCLES-1.
  - BUZZ: cnt decrements each edge. When cnt==0:
    - GAP_CYCLES>0 → GAP, buzzer_out <= 0, busy <= 0, cnt <= GAP_CYCLES-1.
    - GAP_CYCLES==0 → arbitrate immediately as in IDLE; otherwise go to IDLE.
  - GAP: cnt decrements. When cnt==0, arbitrate as in IDLE; with no pending channel, go to IDLE.
- Burst length: buzzer_out is high for exactly ON_CYCLES cycles per grant.
- Latency: sensor high in cycle 0 → pending bit set after edge 1 → buzzer_out high after edge 2 (when idle).
- ena=0 (sampled at an edge): state → IDLE, buzzer_out=0, busy=0, cnt=0. pending keeps capturing; rr_ptr is held. Re-asserting ena resumes arbitration with the next edge.
- Pending bits of channels not granted are never cleared except by rst.
- Counter width is $clog2(max(ON_CYCLES,GAP_CYCLES)+1); no wrap is permitted.
- active_id holds its last value outside BUZZ.

Decomposition:
- Package alarm_sched_pkg:
  - state enum {IDLE, BUZZ, GAP}
  - ID_W=3
  - function onehot(id)
- Sub-module rr_arbiter (combinational): inputs req[N], ptr[ID_W]; outputs gnt_valid, gnt_id. The top level holds the FSM, counter and registers.

Test Plan:
- Reset: rst=1 for 2 cycles with sensor_in=8'hFF → buzzer_out=0, pending=0, busy=0; pending=8'hFF one edge after rst drops; buzzer_out=8'h01 one edge later.
- Single channel: sensor_in[0] high for 1 cycle, defaults → buzzer_out=8'h01 for exactly 10 cycles, 0 for 2 cycles, then IDLE; pending[0]=0 after the grant edge.
- Fairness: sensor_in[1] and sensor_in[2] held high → grants alternate 1,2,1,2; each burst is 10 cycles separated by 2 silent cycles; active_id alternates accordingly.
- All sensors: sensor_in=8'hFF held → grants 0..7 then wrap to 0; buzzer_out is never multi-hot (assert $onehot0 every cycle).
- Mid-burst events:
  - ena dropped at burst cycle 5 → buzzer_out=0 next edge; re-enable → the next channel after rr_ptr is served.
  - rst asserted mid-burst → full reset values next edge.
- GAP_CYCLES=0 build: channels 3 and 5 pending → buzzer_out goes 8'h08 for 10 cycles, then 8'h20 on the very next cycle with no zero cycle.
